// File: rtl/ysyx_store_buffer_pkg.sv
// Shared types for the committed-store buffer: FSM states and entry layout.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

package ysyx_pkg;

    // Entry field width; the store buffer's XLEN parameter is expected to match.
    localparam int SB_XLEN   = `YSYX_XLEN;
    localparam int SB_STRB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sb_state_t;

    typedef struct packed {
        logic [SB_XLEN-1:0]   addr;
        logic [SB_XLEN-1:0]   data;
        logic [SB_STRB_W-1:0] wstrb;
    } sb_entry_t;

endpackage

// File: rtl/ysyx_sb_cam.sv
// Word-address match of a pending load against every valid store entry.
// Latency: purely combinational.
// Backpressure: none; a hit is only advisory for the load pipeline.
module ysyx_sb_cam #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0][XLEN-1:0] entry_addr,
    input  logic [DEPTH-1:0]           entry_valid,
    input  logic [XLEN-1:0]            ld_addr,
    output logic                       hit
);

    logic [DEPTH-1:0] match;

    // Compare bits [XLEN-1:2] only; strobes are ignored so aliasing is conservative.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entry_valid[i] && (entry_addr[i][XLEN-1:2] == ld_addr[XLEN-1:2]);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/ysyx_store_buffer.sv
// In-order FIFO of committed stores draining one write at a time to the bus LSU channel.
// Latency: 2 cycles from accept into an empty buffer to awvalid; one idle GAP cycle after each completion.
// Backpressure: enq_ready = !full (same-cycle pop not seen); head held on the bus until bus_lsu_wready.
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module ysyx_store_buffer
    import ysyx_pkg::*;
#(
    parameter int XLEN  = `YSYX_XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enq_valid,
    output logic            enq_ready,
    input  logic [XLEN-1:0] enq_addr,
    input  logic [XLEN-1:0] enq_data,
    input  logic [7:0]      enq_wstrb,
    output logic [XLEN-1:0] lsu_awaddr,
    output logic            lsu_awvalid,
    output logic [XLEN-1:0] lsu_wdata,
    output logic [7:0]      lsu_wstrb,
    output logic            lsu_wvalid,
    input  logic            bus_lsu_wready,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_conflict,
    output logic            empty
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    sb_entry_t                  mem [DEPTH];
    logic [DEPTH-1:0]           valid;
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [CNT_W-1:0]           count;
    sb_state_t                  state;
    sb_state_t                  state_nxt;
    sb_entry_t                  head_ent;
    logic [DEPTH-1:0][XLEN-1:0] ent_addr;
    logic                       full;
    logic                       push;
    logic                       pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign enq_ready = !full;
    assign push      = enq_valid && enq_ready;
    // Pops only happen while the head is on the bus; a stray wready elsewhere is dropped.
    assign pop       = (state == SEND) && bus_lsu_wready;
    assign head_ent  = mem[head];

    // Payload storage; no reset needed since valid bits gate every use.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[tail] <= '{addr: enq_addr, data: enq_data, wstrb: enq_wstrb};
        end
    end

    // Pointers, occupancy, valid bits and FSM state; reset abandons any in-flight write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
        end else begin
            state <= state_nxt;
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next state and bus outputs; payload is driven only in SEND so it idles at zero.
    always_comb begin
        state_nxt   = state;
        lsu_awvalid = 1'b0;
        lsu_awaddr  = '0;
        lsu_wdata   = '0;
        lsu_wstrb   = '0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = SEND;
            end
            SEND: begin
                lsu_awvalid = 1'b1;
                lsu_awaddr  = head_ent.addr;
                lsu_wdata   = head_ent.data;
                lsu_wstrb   = head_ent.wstrb;
                if (bus_lsu_wready) state_nxt = GAP;
            end
            GAP: begin
                // count here already reflects the pop that entered GAP.
                state_nxt = empty ? IDLE : SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lsu_wvalid = lsu_awvalid;

    // Flatten entry addresses for the match array.
    always_comb begin
        ent_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = mem[i].addr;
        end
    end

    ysyx_sb_cam #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_cam (
        .entry_addr  (ent_addr),
        .entry_valid (valid),
        .ld_addr     (ld_addr),
        .hit         (ld_conflict)
    );

    a_valid_pair: assert property (@(posedge clock) lsu_awvalid == lsu_wvalid);

    a_payload_stable: assert property (@(posedge clock) disable iff (!reset)
        (lsu_awvalid && $past(lsu_awvalid)) |->
        ($stable(lsu_awaddr) && $stable(lsu_wdata) && $stable(lsu_wstrb)));

    a_count_bound: assert property (@(posedge clock) disable iff (!reset) count <= DEPTH_C);

    a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset) !(pop && empty));

endmodule

// File: tb/tb_ysyx_store_buffer.sv
`timescale 1ns/1ps
module tb_ysyx_store_buffer;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            enq_valid = 1'b0;
    logic            enq_ready;
    logic [XLEN-1:0] enq_addr = '0;
    logic [XLEN-1:0] enq_data = '0;
    logic [7:0]      enq_wstrb = '0;
    logic [XLEN-1:0] lsu_awaddr;
    logic            lsu_awvalid;
    logic [XLEN-1:0] lsu_wdata;
    logic [7:0]      lsu_wstrb;
    logic            lsu_wvalid;
    logic            bus_lsu_wready = 1'b0;
    logic [XLEN-1:0] ld_addr = '0;
    logic            ld_conflict;
    logic            empty;

    always #5 clock = ~clock;

    ysyx_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_addr       (enq_addr),
        .enq_data       (enq_data),
        .enq_wstrb      (enq_wstrb),
        .lsu_awaddr     (lsu_awaddr),
        .lsu_awvalid    (lsu_awvalid),
        .lsu_wdata      (lsu_wdata),
        .lsu_wstrb      (lsu_wstrb),
        .lsu_wvalid     (lsu_wvalid),
        .bus_lsu_wready (bus_lsu_wready),
        .ld_addr        (ld_addr),
        .ld_conflict    (ld_conflict),
        .empty          (empty)
    );

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [7:0]      strb;
    } st_t;

    localparam st_t Z = '0;

    // Reference model: stores still owned by the buffer, and stores the bus has yet to see.
    st_t pend_q[$];
    st_t sb_q[$];

    int              tests = 0;
    int              fails = 0;
    logic            aw_s = 1'b0;
    logic [XLEN-1:0] la_cur = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic st_t mk(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [7:0] s);
        st_t r;
        r.addr = a;
        r.data = d;
        r.strb = s;
        return r;
    endfunction

    function automatic logic model_conflict(input logic [XLEN-1:0] la);
        foreach (pend_q[i]) begin
            if (pend_q[i].addr[XLEN-1:2] == la[XLEN-1:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Sample just after the falling edge and compare against the model state.
    task automatic sample();
        @(negedge clock);
        #1;
        aw_s = lsu_awvalid;
        chk1("enq_ready", enq_ready, pend_q.size() < DEPTH);
        chk1("empty", empty, pend_q.size() == 0);
        chki("count", int'(dut.count), pend_q.size());
        chk1("ld_conflict", ld_conflict, model_conflict(ld_addr));
        if (pend_q.size() == 0) chk1("idle_awvalid", lsu_awvalid, 1'b0);
    endtask

    // Drive inputs for the next rising edge and advance the model accordingly.
    task automatic drive(input logic rst, input logic ev, input st_t s, input logic wr);
        logic acc;
        reset          = rst;
        enq_valid      = ev;
        enq_addr       = s.addr;
        enq_data       = s.data;
        enq_wstrb      = s.strb;
        bus_lsu_wready = wr;
        ld_addr        = la_cur;
        if (!rst) begin
            pend_q.delete();
            sb_q.delete();
        end else begin
            acc = ev && (pend_q.size() < DEPTH);
            if (wr && aw_s) void'(pend_q.pop_front());
            if (acc) begin
                pend_q.push_back(s);
                sb_q.push_back(s);
            end
        end
    endtask

    task automatic tick_r(input logic rst, input logic ev, input st_t s, input logic wr);
        drive(rst, ev, s, wr);
        sample();
    endtask

    task automatic tick(input logic ev, input st_t s, input logic wr);
        tick_r(1'b1, ev, s, wr);
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!aw_s && n < 20) begin
            tick(1'b0, Z, 1'b0);
            n++;
        end
        if (!aw_s) begin
            tests++;
            fails++;
            $display("FAIL wait_awvalid: got no request within 20 cycles want a request");
        end
    endtask

    // Complete the current head after lat held cycles; check the single GAP cycle.
    task automatic drain_one(input int lat);
        wait_aw();
        if (aw_s) begin
            repeat (lat) begin
                tick(1'b0, Z, 1'b0);
                chk1("hold_awvalid", aw_s, 1'b1);
            end
            tick(1'b0, Z, 1'b1);
            chk1("gap_awvalid", aw_s, 1'b0);
            tick(1'b0, Z, 1'b0);
            chk1("after_gap_awvalid", aw_s, pend_q.size() != 0);
        end
    endtask

    // Scoreboard monitor: each new request must be the oldest outstanding store, held stable.
    logic mon_act = 1'b0;
    st_t  mon_cur = '0;
    always @(negedge clock) begin
        if (lsu_awvalid === 1'b1) begin
            chk1("wvalid_eq", lsu_wvalid, 1'b1);
            if (!mon_act) begin
                mon_act = 1'b1;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_req: got request addr %h want no request", lsu_awaddr);
                end else begin
                    mon_cur = sb_q.pop_front();
                    chkw("bus_addr", lsu_awaddr, mon_cur.addr);
                    chkw("bus_data", lsu_wdata, mon_cur.data);
                    chkw("bus_strb", {56'd0, lsu_wstrb}, {56'd0, mon_cur.strb});
                end
            end else begin
                chkw("hold_addr", lsu_awaddr, mon_cur.addr);
                chkw("hold_data", lsu_wdata, mon_cur.data);
            end
        end else begin
            mon_act = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   held;
        int   lat;
        logic ev;
        logic wr;
        st_t  s;

        // Reset held two cycles with a store offered: nothing may be captured.
        drive(1'b0, 1'b1, mk(64'h40, 64'h1, 8'hFF), 1'b0);
        sample();
        tick_r(1'b0, 1'b1, mk(64'h40, 64'h1, 8'hFF), 1'b0);
        tick(1'b0, Z, 1'b0);
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_awvalid", lsu_awvalid, 1'b0);
        chk1("rst_ready", enq_ready, 1'b1);
        chki("rst_count", int'(dut.count), 0);
        chkw("rst_awaddr", lsu_awaddr, 64'h0);
        chkw("rst_wdata", lsu_wdata, 64'h0);
        chkw("rst_wstrb", {56'd0, lsu_wstrb}, 64'h0);
        chk1("rst_conflict", ld_conflict, 1'b0);

        // Single store: request two cycles after accept, held for five, one GAP, then idle.
        tick(1'b1, mk(64'h8000_0004, 64'hDEAD_BEEF, 8'h0F), 1'b0);
        chk1("lat_cycle1", aw_s, 1'b0);
        chk1("lat_empty", empty, 1'b0);
        tick(1'b0, Z, 1'b0);
        chk1("lat_cycle2", aw_s, 1'b1);
        drain_one(5);
        chk1("single_empty", empty, 1'b1);

        // Spurious completion pulses while idle are ignored.
        tick(1'b0, Z, 1'b1);
        chk1("spur_aw", aw_s, 1'b0);
        tick(1'b0, Z, 1'b0);
        chk1("spur_empty", empty, 1'b1);

        // Fill, refuse a fifth, drain, refill across the pointer wrap.
        for (int i = 0; i < 4; i++) tick(1'b1, mk(64'h100 + 64'(4 * i), 64'hA0 + 64'(i), 8'hF0), 1'b0);
        chk1("full_ready", enq_ready, 1'b0);
        tick(1'b1, mk(64'h110, 64'hBAD, 8'hFF), 1'b0);
        chki("full_refused", int'(dut.count), 4);
        for (int i = 0; i < 4; i++) drain_one(i);
        for (int i = 0; i < 2; i++) tick(1'b1, mk(64'h120 + 64'(4 * i), 64'hC0 + 64'(i), 8'h3C), 1'b0);
        drain_one(1);
        drain_one(2);

        // Simultaneous enqueue and completion at count 2.
        tick(1'b1, mk(64'h300, 64'h11, 8'h01), 1'b0);
        tick(1'b1, mk(64'h304, 64'h22, 8'h02), 1'b0);
        wait_aw();
        tick(1'b1, mk(64'h308, 64'h33, 8'h04), 1'b1);
        chki("simul_count", int'(dut.count), 2);
        drain_one(0);
        drain_one(3);

        // Load aliasing a pending store word.
        tick(1'b1, mk(64'h200, 64'h55, 8'h01), 1'b0);
        la_cur = 64'h203;
        tick(1'b0, Z, 1'b0);
        chk1("conf_203", ld_conflict, 1'b1);
        la_cur = 64'h204;
        tick(1'b0, Z, 1'b0);
        chk1("conf_204", ld_conflict, 1'b0);
        la_cur = 64'h200;
        tick(1'b0, Z, 1'b0);
        chk1("conf_200", ld_conflict, 1'b1);
        drain_one(2);
        chk1("conf_popped", ld_conflict, 1'b0);

        // Reset in the middle of a SEND with three entries.
        for (int i = 0; i < 3; i++) tick(1'b1, mk(64'h400 + 64'(4 * i), 64'h70 + 64'(i), 8'hFF), 1'b0);
        wait_aw();
        tick(1'b0, Z, 1'b0);
        tick_r(1'b0, 1'b0, Z, 1'b0);
        chk1("midrst_aw", aw_s, 1'b0);
        chk1("midrst_empty", empty, 1'b1);
        tick(1'b0, Z, 1'b0);

        // Randomized traffic with a variable-latency bus responder.
        held = 0;
        lat  = 0;
        for (int c = 0; c < 800; c++) begin
            ev = ($urandom_range(0, 2) != 0);
            s  = mk(64'h1000 + 64'($urandom_range(0, 63)), {$urandom(), $urandom()}, 8'($urandom()));
            wr = 1'b0;
            if (aw_s) begin
                if (held >= lat) begin
                    wr   = 1'b1;
                    held = 0;
                    lat  = $urandom_range(0, 4);
                end else begin
                    held++;
                end
            end else begin
                wr = ($urandom_range(0, 7) == 0);
            end
            la_cur = 64'h1000 + 64'($urandom_range(0, 63));
            tick(ev, s, wr);
        end

        // Let the buffer empty out.
        for (int c = 0; c < 100 && pend_q.size() != 0; c++) tick(1'b0, Z, aw_s);
        chki("final_pending", pend_q.size(), 0);
        repeat (3) tick(1'b0, Z, 1'b0);
        chki("final_sb", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
